// File: rtl/audio_jack_s_axi_regs.sv
// audio_jack_s_axi_regs
// AXI4-Lite slave register block for the audio_jack IP. Buffers samples from
// the capture front end in a FIFO that software drains through SAMPLE.
//
// Register map (word index ADDR[3:2]):
//   0 CTRL   RW  [0] capture enable, [1] flush (write-1, self-clearing),
//                [2] irq enable (stored only with AUDIO_JACK_IRQ_EN)
//   1 STATUS RO  [15:0] level, [16] empty, [17] full, [18] overflow (sticky)
//   2 SAMPLE RO  read pops: [31] valid, [SAMPLE_W-1:0] data
//   3 THRESH RW  all 32 bits stored, [15:0] used for irq
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET      clock, async active-high reset
//   S_AXI_AW*/W*/B*                write address/data/response channels
//   S_AXI_AR*/R*                   read address/data channels
//   sample_valid / sample_data     sample input from the jack front end
//   irq                            level >= threshold interrupt
//                                  (present only with AUDIO_JACK_IRQ_EN)
//
// Optional feature macro: AUDIO_JACK_IRQ_EN
module audio_jack_s_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SAMPLE_W           = 24,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sample_valid,
  input  logic [SAMPLE_W-1:0]             sample_data
`ifdef AUDIO_JACK_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t            r_wstate;
  rstate_t            r_rstate;
  logic               r_bvalid;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic               r_cap_en;
  logic [31:0]        r_thresh;
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [LW-1:0]      r_level;
  logic               r_ovf;
  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
`ifdef AUDIO_JACK_IRQ_EN
  logic               r_irq_en;
  logic               r_irq;
`endif

  logic        w_aw_hs;
  logic        w_ar_hs;
  logic        w_flush;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [31:0] w_rdata;
  logic        w_irq_en;
  logic        w_unused;

  assign w_unused = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready is a decode of the idle state so the handshake completes in the
  // same cycle both VALIDs are seen; held low throughout reset.
  assign w_aw_hs = (r_wstate == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_ARESET;
  assign w_ar_hs = (r_rstate == R_IDLE) && S_AXI_ARVALID && !S_AXI_ARESET;

  assign S_AXI_AWREADY = w_aw_hs;
  assign S_AXI_WREADY  = w_aw_hs;
  assign S_AXI_ARREADY = w_ar_hs;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = '0;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = '0;

`ifdef AUDIO_JACK_IRQ_EN
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  assign w_flush = w_aw_hs && (S_AXI_AWADDR[3:2] == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = w_ar_hs && (S_AXI_ARADDR[3:2] == 2'd2) && !w_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_push  = sample_valid && r_cap_en && (!w_full || w_pop);
  assign w_drop  = sample_valid && r_cap_en && w_full && !w_pop;

  always_comb begin
    w_rdata = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0: w_rdata = {29'b0, w_irq_en, 1'b0, r_cap_en};
      2'd1: w_rdata = {13'b0, r_ovf, w_full, w_empty, 16'(r_level)};
      2'd2: if (!w_empty) begin
              w_rdata[31]           = 1'b1;
              w_rdata[SAMPLE_W-1:0] = r_mem[r_rp];
            end
      default: w_rdata = r_thresh;
    endcase
  end

  // Write channel and register file
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wstate <= W_IDLE;
      r_bvalid <= 1'b0;
      r_cap_en <= 1'b0;
      r_thresh <= '0;
`ifdef AUDIO_JACK_IRQ_EN
      r_irq_en <= 1'b0;
`endif
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_hs) begin
          r_bvalid <= 1'b1;
          r_wstate <= W_RESP;
          case (S_AXI_AWADDR[3:2])
            2'd0: if (S_AXI_WSTRB[0]) begin
              r_cap_en <= S_AXI_WDATA[0];
`ifdef AUDIO_JACK_IRQ_EN
              r_irq_en <= S_AXI_WDATA[2];
`endif
            end
            2'd3: for (int unsigned b = 0; b < 4; b++) begin
              if (S_AXI_WSTRB[b]) r_thresh[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
            default: ;
          endcase
        end
        W_RESP: if (S_AXI_BREADY) begin
          r_bvalid <= 1'b0;
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (w_ar_hs) begin
          r_rdata  <= w_rdata;
          r_rvalid <= 1'b1;
          r_rstate <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          r_rvalid <= 1'b0;
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  // Sample FIFO pointers and flags; flush overrides any same-cycle push/pop
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_push && !w_flush) r_mem[r_wp] <= sample_data;
  end

`ifdef AUDIO_JACK_IRQ_EN
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) r_irq <= 1'b0;
    else r_irq <= r_irq_en && (16'(r_level) >= r_thresh[15:0]) && (r_thresh[15:0] != 16'd0);
  end
`endif

endmodule

// File: tb/tb_audio_jack_s_axi_regs.sv
// Self-checking bench for audio_jack_s_axi_regs: a queue-based reference
// model tracks registers, FIFO contents and outstanding responses; a negedge
// compare process checks every output each cycle, and directed sequences add
// literal expectations on read data.
module tb_audio_jack_s_axi_regs;

  localparam int SW    = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [3:0]    araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
`ifdef AUDIO_JACK_IRQ_EN
  logic          irq;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;
  bit rnd_mode = 0;

  audio_jack_s_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .SAMPLE_W(SW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .sample_valid(sample_valid),
    .sample_data(sample_data)
`ifdef AUDIO_JACK_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SW-1:0] mq[$];
  bit            m_cap, m_irqen, m_ovf, m_bpend, m_rpend, m_irq;
  logic [31:0]   m_thresh, m_rdata;

  always @(posedge clk or posedge rst) begin : model
    bit          aw_acc, ar_acc, pop, irq_next;
    int          lvl;
    logic [31:0] rv;
    if (rst) begin
      mq.delete();
      m_cap = 0; m_irqen = 0; m_ovf = 0; m_bpend = 0; m_rpend = 0; m_irq = 0;
      m_thresh = '0; m_rdata = '0;
    end else begin
      aw_acc = !m_bpend && awvalid && wvalid;
      ar_acc = !m_rpend && arvalid;
      lvl = mq.size();
      irq_next = m_irqen && (lvl >= int'(m_thresh[15:0])) && (m_thresh[15:0] != 16'd0);
      pop = 0;
      rv = '0;
      if (ar_acc) begin
        case (araddr[3:2])
          2'd0: rv = {29'b0, m_irqen, 1'b0, m_cap};
          2'd1: rv = {13'b0, m_ovf, lvl == DEPTH, lvl == 0, 16'(lvl)};
          2'd2: if (lvl > 0) begin rv = 32'h8000_0000 | 32'(mq[0]); pop = 1; end
          default: rv = m_thresh;
        endcase
      end
      if (pop) void'(mq.pop_front());
      if (sample_valid && m_cap) begin
        if (mq.size() < DEPTH) mq.push_back(sample_data);
        else m_ovf = 1;
      end
      if (aw_acc) begin
        case (awaddr[3:2])
          2'd0: if (wstrb[0]) begin
            m_cap = wdata[0];
`ifdef AUDIO_JACK_IRQ_EN
            m_irqen = wdata[2];
`endif
            if (wdata[1]) begin mq.delete(); m_ovf = 0; end
          end
          2'd3: for (int b = 0; b < 4; b++) if (wstrb[b]) m_thresh[b*8 +: 8] = wdata[b*8 +: 8];
          default: ;
        endcase
      end
      if (aw_acc) m_bpend = 1; else if (bready) m_bpend = 0;
      if (ar_acc) begin m_rpend = 1; m_rdata = rv; end else if (rready) m_rpend = 0;
      m_irq = irq_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chkb("awready", awready, !rst && !m_bpend && awvalid && wvalid);
      chkb("wready", wready, !rst && !m_bpend && awvalid && wvalid);
      chkb("arready", arready, !rst && !m_rpend && arvalid);
      chkb("bvalid", bvalid, m_bpend);
      chkb("rvalid", rvalid, m_rpend);
      chk("bresp", 32'(bresp), 32'h0);
      chk("rresp", 32'(rresp), 32'h0);
      if (m_rpend) chk("rdata", rdata, m_rdata);
`ifdef AUDIO_JACK_IRQ_EN
      chkb("irq", irq, m_irq);
`endif
    end
  end

  // Random sample source for the randomized phase
  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      sample_valid = ($urandom % 3 == 0);
      sample_data  = SW'($urandom);
    end
  end

  // ---------------- bus tasks (called #1 after a posedge) ----------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned stall);
    bit hs = 0;
    bit done = 0;
    int unsigned n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = (stall == 0);
    while (!hs && n < 50) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end
    chkb("aw_handshake", hs, 1'b1);
    awvalid = 0; wvalid = 0;
    repeat (stall) begin @(posedge clk); #1; end
    bready = 1;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk); done = bvalid;
      @(posedge clk); #1; n++;
    end
    chkb("b_handshake", done, 1'b1);
    bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] a, input int unsigned stall, input logic sv,
                          input logic [SW-1:0] sd, output logic [31:0] d);
    bit hs = 0;
    bit done = 0;
    int unsigned n = 0;
    d = 'x;
    araddr = a; arvalid = 1; rready = (stall == 0);
    if (sv) begin sample_valid = 1; sample_data = sd; end
    while (!hs && n < 50) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; n++;
    end
    chkb("ar_handshake", hs, 1'b1);
    arvalid = 0;
    if (sv) sample_valid = 0;
    repeat (stall) begin @(posedge clk); #1; end
    rready = 1;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk); done = rvalid; d = rdata;
      @(posedge clk); #1; n++;
    end
    chkb("r_handshake", done, 1'b1);
    rready = 0;
  endtask

  task automatic push(input logic [SW-1:0] d);
    sample_valid = 1; sample_data = d;
    @(posedge clk); #1;
    sample_valid = 0;
  endtask

  task automatic rd_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, 0, 1'b0, '0, d);
    chk(name, d, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int unsigned aw_seen, bv_seen, ar_seen;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    chk_on = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Register write/read-back, RO writes ignored
    axi_write(4'h0, 32'h1, 4'hF, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0);
    axi_write(4'h8, 32'h3, 4'hF, 1);
    axi_write(4'hC, 32'h4, 4'hF, 0);
    rd_expect("ctrl_rb", 4'h0, 32'h1);
    rd_expect("thresh_rb", 4'hC, 32'h4);
    rd_expect("status_empty", 4'h4, 32'h0001_0000);
    rd_expect("sample_empty", 4'h8, 32'h0);

    // Basic capture and drain
    push(24'h000ABC); push(24'h123456); push(24'hFFFFFF);
    rd_expect("status_lvl3", 4'h4, 32'h0000_0003);
    rd_expect("pop0", 4'h8, 32'h8000_0ABC);
    rd_expect("pop1", 4'h8, 32'h8012_3456);
    rd_expect("pop2", 4'h8, 32'h80FF_FFFF);
    rd_expect("pop_empty", 4'h8, 32'h0);

    // Overflow and flush
    for (int i = 0; i < 18; i++) push(SW'(i + 32'h100));
    rd_expect("status_ovf", 4'h4, 32'h0006_0010);
    axi_write(4'h0, 32'h3, 4'h1, 0);
    rd_expect("status_flushed", 4'h4, 32'h0001_0000);
    rd_expect("ctrl_after_flush", 4'h0, 32'h1);

    // Push at full coinciding with a pop
    for (int i = 0; i < 16; i++) push(SW'(i + 1));
    axi_read(4'h8, 0, 1'b1, 24'h00ABCD, d);
    chk("pop_at_full", d, 32'h8000_0001);
    rd_expect("status_full_noovf", 4'h4, 32'h0002_0010);
    for (int i = 0; i < 15; i++) axi_read(4'h8, 0, 1'b0, '0, d);
    rd_expect("tail_sample", 4'h8, 32'h8000_ABCD);

    // Byte strobes on THRESH
    axi_write(4'hC, 32'hA1B2C3D4, 4'b0101, 0);
    rd_expect("thresh_strb", 4'hC, 32'h00B200D4);

`ifdef AUDIO_JACK_IRQ_EN
    axi_write(4'hC, 32'h4, 4'hF, 0);
    axi_write(4'h0, 32'h5, 4'hF, 0);
    rd_expect("ctrl_irq", 4'h0, 32'h5);
    push(24'h1); push(24'h2); push(24'h3);
    push(24'h4);
    chkb("irq_pre", irq, 1'b0);
    @(posedge clk); #1;
    chkb("irq_set", irq, 1'b1);
    axi_read(4'h8, 0, 1'b0, '0, d);
    chkb("irq_clr", irq, 1'b0);
    axi_write(4'h0, 32'h3, 4'hF, 0);
`endif

    // Response stall: BVALID held, no second write accepted
    axi_write(4'hC, 32'h0, 4'hF, 0);
    awaddr = 4'hC; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    wdata = 32'h12345678;
    aw_seen = 0; bv_seen = 0;
    repeat (5) begin
      @(negedge clk); aw_seen += awready; bv_seen += bvalid;
      @(posedge clk); #1;
    end
    chk("aw_during_stall", aw_seen, 0);
    chk("bvalid_held", bv_seen, 5);
    awvalid = 0; wvalid = 0; bready = 1;
    @(posedge clk); #1;
    bready = 0;

    // Read stall then reset with RVALID high
    araddr = 4'hC; arvalid = 1; rready = 0;
    @(posedge clk); #1;
    ar_seen = 0;
    repeat (5) begin
      @(negedge clk); ar_seen += arready; chk("rdata_held", rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    chk("ar_during_stall", ar_seen, 0);
    rst = 1;
    #1;
    chkb("rvalid_in_reset", rvalid, 1'b0);
    arvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rd_expect("ctrl_after_rst", 4'h0, 32'h0);
    rd_expect("status_after_rst", 4'h4, 32'h0001_0000);
    rd_expect("sample_after_rst", 4'h8, 32'h0);
    rd_expect("thresh_after_rst", 4'hC, 32'h0);

    // Randomized traffic against the model
    axi_write(4'h0, 32'h1, 4'hF, 0);
    rnd_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      logic [3:0]  a;
      logic [31:0] v;
      op = $urandom % 5;
      a = {2'($urandom), 2'b00};
      if (op == 0) begin
        if (a[3:2] == 2'd0) v = {29'($urandom), 1'($urandom), ($urandom % 8 == 0), ($urandom % 4 != 0)};
        else v = {16'($urandom), 16'($urandom % 20)};
        axi_write(a, v, 4'($urandom), $urandom % 3);
      end else begin
        if (op >= 3) a = 4'h8;
        axi_read(a, $urandom % 3, 1'b0, '0, v);
      end
    end
    rnd_mode = 0;
    @(posedge clk); #1;
    sample_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/audio_jack_s_axi_regs.md
Name: audio_jack_s_axi_regs

Overview:
AXI4-Lite slave register block for the audio_jack IP, the responder end of the master-driven register accesses used in the audio_jack system bench. Exposes control, status, a sample-pop register and a threshold register to the PS. Buffers incoming audio samples from the jack/codec front end in an internal FIFO, which software drains through the SAMPLE register. Sits between the AXI interconnect and the audio capture front end.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, AXI address width; 4 word registers
SAMPLE_W, 24, audio sample width, 1..31
FIFO_DEPTH, 16, sample FIFO depth; power of 2, 2..1024

Ports:
S_AXI_ACLK  in  1  single clock for bus and sample logic
S_AXI_ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
sample_valid  in  1  new sample this cycle
sample_data  in  SAMPLE_W  sample value

Behaviour:
- Reset: all outputs 0; CTRL=0, THRESH=0, FIFO empty, overflow flag 0. Reset mid-transaction aborts it: VALIDs drop immediately, and no pending response is issued afterwards.
- Register map, word index ADDR[3:2]:
  - 0 CTRL (RW): [0] capture enable; [1] flush, write-1 self-clearing, never reads 1; [2] irq enable, see Optional Feature.
  - 1 STATUS (RO): [15:0] level; [16] empty; [17] full; [18] overflow sticky.
  - 2 SAMPLE (RO, read pops): [31] valid, [SAMPLE_W-1:0] data, other bits 0.
  - 3 THRESH (RW): [15:0] used; all 32 bits are stored and read back.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE with AWVALID&&WVALID both high: AWREADY and WREADY pulse together for 1 cycle and the register updates per WSTRB in that same cycle.
  - Next cycle: BVALID=1 (W_RESP), held until BREADY. A new write is accepted only from W_IDLE.
  - AWVALID alone or WVALID alone is never accepted.
  - Writes to RO registers are ignored but still get BRESP OKAY.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE with ARVALID: ARREADY pulses 1 cycle, and RDATA is captured then.
  - Next cycle: RVALID=1, with RDATA held stable until RREADY.
  - Read latency is 1 cycle from the AR handshake.
- FIFO push: when sample_valid && CTRL[0] && !full. If full and not popping that cycle, the sample is dropped and overflow is set.
- FIFO pop: on an AR handshake to SAMPLE while non-empty; RDATA = {1'b1, zero pad, head}.
  - Empty pop returns 0x00000000; pointers unchanged, no error response.
- Simultaneous push and pop: both occur and level is unchanged; at full, the push is accepted.
- Flush (CTRL[1] written 1): pointers zero, level 0, overflow cleared. Flush has priority over a same-cycle push.
- STATUS read while a push occurs returns the pre-push value.
- Pointers wrap modulo FIFO_DEPTH. Level counts 0..FIFO_DEPTH and is zero-extended to 16 bits.

Optional Feature:
Macro AUDIO_JACK_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0), registered, irq = CTRL[2] && (level >= THRESH[15:0]) && (THRESH[15:0] != 0); updates 1 cycle after level or register change.
- Undefined: no irq port; CTRL[2] is not stored and reads 0.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four -> CTRL=0x1, THRESH=0x4, STATUS=0x00010000 (empty), SAMPLE=0x0; every BRESP/RRESP=00.
- CTRL=1, push 3 samples 0x000ABC,0x123456,0xFFFFFF; read STATUS -> 0x3; read SAMPLE three times -> 0x80000ABC, 0x80123456, 0x80FFFFFF; fourth read -> 0x0.
- Push 18 samples into depth-16 FIFO -> STATUS=0x00060010 (full+overflow); write CTRL=0x3 -> STATUS=0x00010000, CTRL reads 0x1.
- Full FIFO, sample_valid asserted in the same cycle as a SAMPLE pop -> level stays 16, overflow not set, last sample appears at the tail.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA remain stable, no second AWREADY/ARREADY; assert S_AXI_ARESET while RVALID=1 -> RVALID=0 within the reset cycle, all registers 0.
- With AUDIO_JACK_IRQ_EN: THRESH=4, CTRL=0x5, push 4 samples -> irq=1 one cycle after the 4th push; pop one -> irq=0.
